// File: rtl/rx_cmd_ctrl.sv
// Byte-stream command decoder: HEADER, addr, data [, csum] -> one register write.
// Optional checksum byte enabled by defining RX_CMD_CHECKSUM_EN.
module rx_cmd_ctrl #(
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter logic [15:0] TIMEOUT_TICK = 16'd4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sample_tick,
  input  logic       i_rx_done_tick,
  input  logic [7:0] i_rx_data,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy,
  output logic       o_err_tick,
  output logic [7:0] o_pkt_count
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_WRITE} state_t;

  localparam logic [15:0] TMO_LAST = TIMEOUT_TICK - 16'd1;

  // Handshake: i_rx_done_tick is a valid-only strobe with no back-pressure;
  // every pulse carries one byte on i_rx_data and is consumed in that cycle.
  state_t      state;
  logic [7:0]  pend_addr;
  logic [15:0] tmo_cnt;

`ifdef RX_CMD_CHECKSUM_EN
  logic [7:0] pend_data;
  logic [7:0] csum_exp;
  assign csum_exp = pend_addr + pend_data;
`endif

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pend_addr   <= '0;
      tmo_cnt     <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_err_tick  <= 1'b0;
      o_pkt_count <= '0;
`ifdef RX_CMD_CHECKSUM_EN
      pend_data   <= '0;
`endif
    end else begin
      o_wr_en    <= 1'b0;
      o_err_tick <= 1'b0;
      case (state)
        // S_WRITE behaves like S_IDLE so a back-to-back HEADER is not lost
        S_IDLE, S_WRITE: begin
          tmo_cnt <= '0;
          if (i_rx_done_tick && (i_rx_data == HEADER)) state <= S_ADDR;
          else                                          state <= S_IDLE;
        end
        default: begin
          if (i_rx_done_tick) begin
            tmo_cnt <= '0;
            case (state)
              S_ADDR: begin
                pend_addr <= i_rx_data;
                state     <= S_DATA;
              end
`ifdef RX_CMD_CHECKSUM_EN
              S_DATA: begin
                pend_data <= i_rx_data;
                state     <= S_CSUM;
              end
              S_CSUM: begin
                if (i_rx_data == csum_exp) begin
                  o_wr_en     <= 1'b1;
                  o_wr_addr   <= pend_addr;
                  o_wr_data   <= pend_data;
                  o_pkt_count <= o_pkt_count + 8'd1;
                  state       <= S_WRITE;
                end else begin
                  o_err_tick <= 1'b1;
                  pend_addr  <= '0;
                  pend_data  <= '0;
                  state      <= S_IDLE;
                end
              end
`else
              S_DATA: begin
                o_wr_en     <= 1'b1;
                o_wr_addr   <= pend_addr;
                o_wr_data   <= i_rx_data;
                o_pkt_count <= o_pkt_count + 8'd1;
                state       <= S_WRITE;
              end
`endif
              default: state <= S_IDLE;
            endcase
          end else if (i_sample_tick) begin
            // A byte in the same cycle takes priority over the timeout
            if (tmo_cnt == TMO_LAST) begin
              o_err_tick <= 1'b1;
              pend_addr  <= '0;
`ifdef RX_CMD_CHECKSUM_EN
              pend_data  <= '0;
`endif
              tmo_cnt    <= '0;
              state      <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Self-checking bench for rx_cmd_ctrl; writes are scored against an expected queue.
// Build with or without RX_CMD_CHECKSUM_EN to match the design.
module tb_rx_cmd_ctrl;

  localparam logic [7:0]  HDR = 8'hA5;
  localparam logic [15:0] TMO = 16'd16;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_sample_tick;
  logic       i_rx_done_tick;
  logic [7:0] i_rx_data;
  logic       o_wr_en;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_busy;
  logic       o_err_tick;
  logic [7:0] o_pkt_count;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int err_seen = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_pkt;

  rx_cmd_ctrl #(.HEADER(HDR), .TIMEOUT_TICK(TMO)) dut (
    .clk(clk), .rst(rst), .i_sample_tick(i_sample_tick),
    .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_err_tick(o_err_tick), .o_pkt_count(o_pkt_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (o_wr_en && o_err_tick) begin
        checks++; errors++;
        $display("FAIL wr_err_overlap: o_wr_en=1 o_err_tick=1, required never both high");
      end
      if (o_err_tick) err_seen++;
      if (o_wr_en) begin
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h, required no write", o_wr_addr, o_wr_data);
        end else begin
          logic [15:0] exp;
          exp = exp_q.pop_front();
          if ({o_wr_addr, o_wr_data} !== exp) begin
            errors++;
            $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                     o_wr_addr, o_wr_data, exp[15:8], exp[7:0]);
          end
        end
      end
    end
  end

  // driver tasks (entered at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b);
    i_rx_data      = b;
    i_rx_done_tick = 1'b1;
    @(negedge clk);
    i_rx_done_tick = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] cs;
    cs = a + d;
    send_byte(HDR);
    send_byte(a);
    exp_q.push_back({a, d});
    exp_pkt = exp_pkt + 8'd1;
`ifdef RX_CMD_CHECKSUM_EN
    send_byte(d);
    send_byte(cs);
`else
    send_byte(d);
`endif
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_pkt = 8'd0;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks += 6;
    if (o_wr_en !== 1'b0)      begin errors++; $display("FAIL reset_wr_en: got %b, required 0", o_wr_en); end
    if (o_wr_addr !== 8'h00)   begin errors++; $display("FAIL reset_wr_addr: got %h, required 00", o_wr_addr); end
    if (o_wr_data !== 8'h00)   begin errors++; $display("FAIL reset_wr_data: got %h, required 00", o_wr_data); end
    if (o_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
    if (o_err_tick !== 1'b0)   begin errors++; $display("FAIL reset_err_tick: got %b, required 0", o_err_tick); end
    if (o_pkt_count !== 8'h00) begin errors++; $display("FAIL reset_pkt_count: got %h, required 00", o_pkt_count); end
    do_reset();
  endtask

  task automatic test_good_packet();
    int e0;
    e0 = err_seen;
    send_byte(HDR);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_after_header: got %b, required 1", o_busy); end
    send_byte(8'h10);
    exp_q.push_back({8'h10, 8'h3C});
    exp_pkt = exp_pkt + 8'd1;
`ifdef RX_CMD_CHECKSUM_EN
    send_byte(8'h3C);
    send_byte(8'h4C);
`else
    send_byte(8'h3C);
`endif
    checks++;
    if (o_wr_en !== 1'b1) begin errors++; $display("FAIL wr_latency: o_wr_en=%b one cycle after last byte, required 1", o_wr_en); end
    @(negedge clk);
    checks++;
    if (o_wr_en !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: o_wr_en=%b second cycle, required 0", o_wr_en); end
    wait_drain();
    repeat (3) @(negedge clk);
    checks += 5;
    if (exp_q.size() != 0)      begin errors++; $display("FAIL good_drain: %0d writes missing, required 0", exp_q.size()); end
    if (o_pkt_count !== exp_pkt) begin errors++; $display("FAIL good_pkt_count: got %h, required %h", o_pkt_count, exp_pkt); end
    if (o_wr_addr !== 8'h10 || o_wr_data !== 8'h3C)
      begin errors++; $display("FAIL good_hold: got addr=%h data=%h, required 10/3C", o_wr_addr, o_wr_data); end
    if (o_busy !== 1'b0)        begin errors++; $display("FAIL good_busy_idle: got %b, required 0", o_busy); end
    if (err_seen != e0)         begin errors++; $display("FAIL good_no_err: got %0d errors ticks, required 0", err_seen - e0); end
  endtask

  task automatic test_garbage();
    int e0;
    int w0;
    e0 = err_seen;
    w0 = wr_seen;
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL garbage_busy: got %b, required 0", o_busy); end
    send_pkt(8'h01, 8'h02);
    wait_drain();
    settle();
    checks += 2;
    if (wr_seen - w0 != 1) begin errors++; $display("FAIL garbage_writes: got %0d, required 1", wr_seen - w0); end
    if (err_seen != e0)    begin errors++; $display("FAIL garbage_err: got %0d, required 0", err_seen - e0); end
  endtask

  task automatic test_timeout();
    int e0;
    int w0;
    e0 = err_seen;
    w0 = wr_seen;
    send_byte(HDR);
    send_byte(8'h20);
    i_sample_tick = 1'b1;
    repeat (TMO - 1) @(negedge clk);
    checks += 2;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL timeout_early_busy: got %b, required 1", o_busy); end
    if (err_seen != e0)  begin errors++; $display("FAIL timeout_early_err: got %0d, required 0", err_seen - e0); end
    @(negedge clk);
    i_sample_tick = 1'b0;
    settle();
    checks += 3;
    if (err_seen - e0 != 1) begin errors++; $display("FAIL timeout_err: got %0d, required 1", err_seen - e0); end
    if (wr_seen != w0)      begin errors++; $display("FAIL timeout_write: got %0d, required 0", wr_seen - w0); end
    if (o_busy !== 1'b0)    begin errors++; $display("FAIL timeout_busy: got %b, required 0", o_busy); end
  endtask

  task automatic test_byte_beats_timeout();
    int e0;
    e0 = err_seen;
    send_byte(HDR);
    send_byte(8'h20);
    i_sample_tick = 1'b1;
    repeat (TMO - 1) @(negedge clk);
    exp_q.push_back({8'h20, 8'h77});
    exp_pkt = exp_pkt + 8'd1;
`ifdef RX_CMD_CHECKSUM_EN
    send_byte(8'h77);
    i_sample_tick = 1'b0;
    send_byte(8'h97);
`else
    send_byte(8'h77);
    i_sample_tick = 1'b0;
`endif
    wait_drain();
    settle();
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL race_drain: %0d writes missing, required 0", exp_q.size()); end
    if (err_seen != e0)    begin errors++; $display("FAIL race_err: got %0d, required 0", err_seen - e0); end
    if (o_pkt_count !== exp_pkt) begin errors++; $display("FAIL race_pkt_count: got %h, required %h", o_pkt_count, exp_pkt); end
  endtask

  task automatic test_header_mid();
    send_pkt(HDR, HDR);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL header_mid_drain: %0d writes missing, required 0", exp_q.size()); end
  endtask

`ifdef RX_CMD_CHECKSUM_EN
  task automatic test_bad_csum();
    int e0;
    int w0;
    e0 = err_seen;
    w0 = wr_seen;
    send_byte(HDR);
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h00);
    settle();
    settle();
    checks += 3;
    if (err_seen - e0 != 1)      begin errors++; $display("FAIL csum_err: got %0d, required 1", err_seen - e0); end
    if (wr_seen != w0)           begin errors++; $display("FAIL csum_write: got %0d, required 0", wr_seen - w0); end
    if (o_pkt_count !== exp_pkt) begin errors++; $display("FAIL csum_pkt_count: got %h, required %h", o_pkt_count, exp_pkt); end
  endtask
`endif

  task automatic test_reset_mid();
    int e0;
    int w0;
    e0 = err_seen;
    w0 = wr_seen;
    send_byte(HDR);
    send_byte(8'h10);
    rst = 1'b1;
    #1;
    checks += 4;
    if (o_busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b, required 0", o_busy); end
    if (o_pkt_count !== 8'h00) begin errors++; $display("FAIL rstmid_pkt_count: got %h, required 00", o_pkt_count); end
    if (o_wr_addr !== 8'h00 || o_wr_data !== 8'h00)
      begin errors++; $display("FAIL rstmid_wr_regs: got addr=%h data=%h, required 00/00", o_wr_addr, o_wr_data); end
    if (o_wr_en !== 1'b0 || o_err_tick !== 1'b0)
      begin errors++; $display("FAIL rstmid_strobes: got wr=%b err=%b, required 0/0", o_wr_en, o_err_tick); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_pkt = 8'd0;
    @(negedge clk);
    send_pkt(8'h55, 8'h66);
    wait_drain();
    settle();
    checks += 3;
    if (wr_seen - w0 != 1)       begin errors++; $display("FAIL rstmid_writes: got %0d, required 1", wr_seen - w0); end
    if (err_seen != e0)          begin errors++; $display("FAIL rstmid_err: got %0d, required 0", err_seen - e0); end
    if (o_pkt_count !== exp_pkt) begin errors++; $display("FAIL rstmid_pkt_count_after: got %h, required %h", o_pkt_count, exp_pkt); end
  endtask

  task automatic test_back_to_back();
    int w0;
    int e0;
    do_reset();
    w0 = wr_seen;
    e0 = err_seen;
    for (int p = 0; p < 256; p++)
      send_pkt(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_drain();
    settle();
    checks += 4;
    if (exp_q.size() != 0)   begin errors++; $display("FAIL b2b_drain: %0d writes missing, required 0", exp_q.size()); end
    if (wr_seen - w0 != 256) begin errors++; $display("FAIL b2b_writes: got %0d, required 256", wr_seen - w0); end
    if (o_pkt_count !== 8'h00) begin errors++; $display("FAIL b2b_wrap: got %h, required 00", o_pkt_count); end
    if (err_seen != e0)      begin errors++; $display("FAIL b2b_err: got %0d, required 0", err_seen - e0); end
  endtask

  initial begin
    rst            = 1'b1;
    i_sample_tick  = 1'b0;
    i_rx_done_tick = 1'b0;
    i_rx_data      = 8'h00;
    exp_pkt        = 8'd0;
    test_reset();
    test_good_packet();
    test_garbage();
    test_timeout();
    test_byte_beats_timeout();
    test_header_mid();
`ifdef RX_CMD_CHECKSUM_EN
    test_bad_csum();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
